// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state, tag-access and conflict-exchange encodings
package cache_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_NORM,
        ST_WAIT_MEM,
        ST_CHECK_CONFLICT,
        ST_WAIT_CONFLICT,
        ST_ALLOCATE_LINE,
        ST_FETCH_REQ,
        ST_WAIT_FETCH,
        ST_ACC_MEM
    } rd_state_e;

    localparam logic [1:0] ACC_LOOKUP = 2'b00;
    localparam logic [1:0] ACC_ALLOC  = 2'b10;
    localparam logic [1:0] ACC_TOUCH  = 2'b11;

    localparam logic [2:0] ACC_MISS       = 3'b000;
    localparam logic [2:0] ACC_MISS_DIRTY = 3'b100;
    localparam logic [2:0] ACC_HIT        = 3'b001;
    localparam logic [2:0] ACC_HIT_DIRTY  = 3'b010;

    localparam logic [2:0] PROC_IDLE  = 3'b000;
    localparam logic [2:0] PROC_CHECK = 3'b001;
    localparam logic [2:0] PROC_BUSY  = 3'b010;
    localparam logic [2:0] PROC_DONE  = 3'b011;

    function automatic logic is_hit(input logic [2:0] status);
        return (status == ACC_HIT) || (status == ACC_HIT_DIRTY);
    endfunction

endpackage

// File: rtl/rd_id_fifo.sv
// rtl/rd_id_fifo.sv - port-id FIFO pairing outstanding data-RAM reads with their requester
module rd_id_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  slots [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/rd_ctrl_mp.sv
// rtl/rd_ctrl_mp.sv - multi-port cache read controller: arbitration, hit/miss handling, line fill
module rd_ctrl_mp
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LIST_DEPTH = 4,
    parameter int LIST_WIDTH = 32,
    parameter int NUM_PORTS  = 2,
    parameter int MAX_OUT    = 4,
    localparam int TW = $clog2(LIST_DEPTH),
    localparam int WW = $clog2(LIST_WIDTH),
    localparam int BW = $clog2(DATA_W / 8),
    localparam int OW = WW + BW,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        rd_valid,
    output logic [NUM_PORTS-1:0]        rd_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_data_valid,
    output logic [PW-1:0]               rd_data_port,
    output logic                        acc_req,
    output logic [1:0]                  acc_cmd,
    output logic [ADDR_W-1:0]           acc_index,
    output logic [TW-1:0]               acc_tag,
    input  logic [2:0]                  acc_status,
    input  logic [TW-1:0]               return_tag,
    input  logic [ADDR_W-1:0]           return_index,
    input  logic                        allocate_busy,
    output logic [2:0]                  proc_status_r,
    output logic [ADDR_W-1:0]           proc_addr_r,
    output logic [TW-1:0]               proc_tag_r,
    input  logic [2:0]                  proc_status_w,
    input  logic [ADDR_W-1:0]           proc_addr_w,
    input  logic [TW-1:0]               proc_tag_w,
    output logic                        fetch_req,
    output logic [1:0]                  fetch_cmd,
    output logic [TW-1:0]               fetch_tag,
    output logic [ADDR_W-1:0]           fetch_addr,
    output logic [ADDR_W-1:0]           fetch_addr_pre,
    input  logic                        fetch_gnt,
    input  logic                        fetch_done,
    output logic                        mem_ren,
    output logic [TW+WW-1:0]            mem_raddr,
    input  logic                        mem_rready,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_rdata_valid,
    output logic                        err_orphan
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OW) - ADDR_W'(1));

    rd_state_e         state, state_nx;
    logic [PW-1:0]     rr_ptr, sel, port_q, push_id, fifo_head;
    logic              found, can_accept, handshake, push, pop, fifo_full, fifo_empty;
    logic [ADDR_W-1:0] sel_addr, addr_q, cur_addr, line_addr, victim_q;
    logic [WW-1:0]     word_off;
    logic [TW-1:0]     tag_q;
    logic [1:0]        fetch_cmd_q;
    logic              err_q;

    // Lowest valid port at or above the pointer wins; otherwise wrap to the lowest valid port.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        sel_addr = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--)
            if (rd_valid[j]) begin
                sel   = PW'(j);
                found = 1'b1;
            end
        for (int j = NUM_PORTS - 1; j >= 0; j--)
            if (rd_valid[j] && (j >= int'(rr_ptr))) sel = PW'(j);
        for (int j = 0; j < NUM_PORTS; j++)
            if (PW'(j) == sel) sel_addr = rd_addr[j*ADDR_W +: ADDR_W];
    end

    // Reset gating keeps every output quiet while rst_n is held low.
    assign can_accept = rst_n && ((state == ST_IDLE) || (state == ST_NORM)) && !fifo_full;
    assign handshake  = can_accept && found;
    assign rd_ready   = handshake ? (NUM_PORTS'(1) << sel) : '0;

    assign cur_addr       = handshake ? sel_addr : addr_q;
    assign line_addr      = cur_addr & LINE_MASK;
    assign word_off       = WW'(cur_addr >> BW);
    assign acc_index      = line_addr;
    assign proc_addr_r    = line_addr;
    assign fetch_addr     = line_addr;
    assign fetch_addr_pre = victim_q;
    assign fetch_tag      = tag_q;
    assign proc_tag_r     = tag_q;
    assign fetch_cmd      = fetch_cmd_q;
    assign err_orphan     = err_q;

    always_comb begin
        state_nx      = state;
        acc_req       = 1'b0;
        acc_cmd       = ACC_LOOKUP;
        acc_tag       = '0;
        proc_status_r = PROC_IDLE;
        fetch_req     = 1'b0;
        mem_ren       = 1'b0;
        mem_raddr     = {tag_q, word_off};
        push          = 1'b0;
        case (state)
            ST_IDLE, ST_NORM: begin
                state_nx = ST_IDLE;
                if (handshake) begin
                    acc_req = 1'b1;
                    if (is_hit(acc_status)) begin
                        mem_ren   = 1'b1;
                        mem_raddr = {return_tag, word_off};
                        push      = mem_rready;
                        state_nx  = mem_rready ? ST_NORM : ST_WAIT_MEM;
                    end else begin
                        state_nx = ST_CHECK_CONFLICT;
                    end
                end
            end
            ST_WAIT_MEM: begin
                mem_ren = 1'b1;
                if (mem_rready) begin
                    push     = 1'b1;
                    state_nx = ST_NORM;
                end
            end
            ST_CHECK_CONFLICT: begin
                proc_status_r = PROC_CHECK;
                if (((proc_status_w == PROC_CHECK) || (proc_status_w == PROC_BUSY)) &&
                    ((proc_addr_w & LINE_MASK) == line_addr))
                    state_nx = ST_WAIT_CONFLICT;
                else
                    state_nx = ST_ALLOCATE_LINE;
            end
            ST_WAIT_CONFLICT: begin
                if (proc_status_w == PROC_DONE) state_nx = ST_ACC_MEM;
            end
            ST_ALLOCATE_LINE: begin
                proc_status_r = PROC_BUSY;
                acc_req       = 1'b1;
                acc_cmd       = ACC_ALLOC;
                if (!allocate_busy) state_nx = ST_FETCH_REQ;
            end
            ST_FETCH_REQ: begin
                proc_status_r = PROC_BUSY;
                fetch_req     = 1'b1;
                if (fetch_gnt) state_nx = ST_WAIT_FETCH;
            end
            ST_WAIT_FETCH: begin
                proc_status_r = PROC_BUSY;
                if (fetch_done) state_nx = ST_ACC_MEM;
            end
            ST_ACC_MEM: begin
                proc_status_r = PROC_BUSY;
                mem_ren       = 1'b1;
                if (mem_rready) begin
                    push          = 1'b1;
                    acc_req       = 1'b1;
                    acc_cmd       = ACC_TOUCH;
                    acc_tag       = tag_q;
                    proc_status_r = PROC_DONE;
                    state_nx      = ST_NORM;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            addr_q      <= '0;
            port_q      <= '0;
            tag_q       <= '0;
            victim_q    <= '0;
            fetch_cmd_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nx;
            if (handshake) begin
                rr_ptr <= (int'(sel) == NUM_PORTS - 1) ? '0 : sel + 1'b1;
                addr_q <= sel_addr;
                port_q <= sel;
                tag_q  <= return_tag;
            end
            if (state == ST_ALLOCATE_LINE) begin
                tag_q       <= return_tag;
                victim_q    <= return_index;
                fetch_cmd_q <= acc_status[1:0];
            end
            if ((state == ST_WAIT_CONFLICT) && (proc_status_w == PROC_DONE)) tag_q <= proc_tag_w;
            if (mem_rdata_valid && fifo_empty) err_q <= 1'b1;
        end
    end

    assign push_id       = handshake ? sel : port_q;
    assign pop           = mem_rdata_valid && !fifo_empty;
    assign rd_data_valid = pop;
    assign rd_data       = pop ? mem_rdata : '0;
    assign rd_data_port  = fifo_empty ? '0 : fifo_head;

    rd_id_fifo #(
        .W     (PW),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_id),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
